// File: rtl/adxl345_pkg.sv
// Shared definitions for the ADXL345 SPI responder: register map, frame layout, FSM states.
// Optional feature macro: ADXL345_RESPONDER_MULTIBYTE_EN (used in adxl345_spi_responder.sv).
package adxl345_pkg;

   localparam logic [7:0] DEVID_DEFAULT = 8'hE5;
   localparam logic [7:0] BW_RATE_RESET = 8'h0A;

   localparam logic [5:0] REG_DEVID       = 6'h00;
   localparam logic [5:0] REG_THRESH_TAP  = 6'h1D;
   localparam logic [5:0] REG_BW_RATE     = 6'h2C;
   localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
   localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
   localparam logic [5:0] REG_DATAX0      = 6'h32;
   localparam logic [5:0] REG_DATAX1      = 6'h33;
   localparam logic [5:0] REG_DATAY0      = 6'h34;
   localparam logic [5:0] REG_DATAY1      = 6'h35;
   localparam logic [5:0] REG_DATAZ0      = 6'h36;
   localparam logic [5:0] REG_DATAZ1      = 6'h37;
   localparam logic [5:0] REG_FIFO_CTL    = 6'h38;
   localparam logic [5:0] REG_FIFO_STATUS = 6'h39;

   localparam int FRAME_RW_BIT   = 15;
   localparam int FRAME_MB_BIT   = 14;
   localparam int FRAME_ADDR_LSB = 8;
   localparam int CMD_RW_BIT     = FRAME_RW_BIT - FRAME_ADDR_LSB;
   localparam int CMD_MB_BIT     = FRAME_MB_BIT - FRAME_ADDR_LSB;

   localparam logic [3:0] CMD_LAST_CNT   = 4'd7;
   localparam logic [3:0] DATA_FIRST_CNT = 4'd8;
   localparam logic [3:0] FRAME_LAST_CNT = 4'd15;

   typedef enum logic [2:0] {
      ST_WAIT_CS_HIGH,
      ST_IDLE,
      ST_CMD,
      ST_DATA,
      ST_DONE
   } state_t;

   function automatic logic is_writable(input logic [5:0] a);
      return (a >= REG_THRESH_TAP && a <= REG_DATA_FORMAT) ||
             a == REG_FIFO_CTL || a == REG_FIFO_STATUS;
   endfunction

   function automatic logic is_sample(input logic [5:0] a);
      return a >= REG_DATAX0 && a <= REG_DATAZ1;
   endfunction

endpackage

// File: rtl/adxl345_spi_responder_pin_sync.sv
// Two-flop synchronizers for the async SPI pins plus edge detection off the third stage.
module spi_pin_sync (
   input  logic sys_clk,
   input  logic reset,
   input  logic spi_sclk,
   input  logic spi_cs_n,
   input  logic spi_mosi,
   output logic sclk_rise,
   output logic sclk_fall,
   output logic cs_fall,
   output logic cs_rise,
   output logic cs_n_s,
   output logic mosi_s
);

   logic [2:0] sclk_q;
   logic [2:0] cs_q;
   logic [1:0] mosi_q;

   // cs resets to "selected" so the host must show a real deselect before any frame decodes
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         sclk_q <= 3'b111;
         cs_q   <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         sclk_q <= {sclk_q[1:0], spi_sclk};
         cs_q   <= {cs_q[1:0], spi_cs_n};
         mosi_q <= {mosi_q[0], spi_mosi};
      end
   end

   assign sclk_rise = sclk_q[1] & ~sclk_q[2];
   assign sclk_fall = ~sclk_q[1] & sclk_q[2];
   assign cs_rise   = cs_q[1] & ~cs_q[2];
   assign cs_fall   = ~cs_q[1] & cs_q[2];
   assign cs_n_s    = cs_q[1];
   assign mosi_s    = mosi_q[1];

endmodule

// File: rtl/adxl345_spi_responder.sv
// ADXL345 register-interface emulator on SPI mode 3, 16-bit frames.
// Optional: ADXL345_RESPONDER_MULTIBYTE_EN enables MB burst transfers with auto-increment.
//
// state        | meaning
// WAIT_CS_HIGH | after reset, waiting for a clean deselect
// IDLE         | deselected, waiting for cs_n fall
// CMD          | shifting R/nW, MB, address
// DATA         | shifting data byte(s)
// DONE         | frame complete, ignoring SCLK until deselect
module adxl345_spi_responder
   import adxl345_pkg::*;
#(
   parameter int         SCLK_MIN_RATIO = 8,
   parameter logic [7:0] DEVID_VALUE    = DEVID_DEFAULT
) (
   input  logic        sys_clk,
   input  logic        reset,
   input  logic        spi_sclk,
   input  logic        spi_cs_n,
   input  logic        spi_mosi,
   output logic        spi_miso,
   output logic        spi_miso_oe,
   input  logic        sample_valid,
   input  logic [15:0] sample_x,
   input  logic [15:0] sample_y,
   input  logic [15:0] sample_z,
   output logic        reg_wr_valid,
   output logic [5:0]  reg_wr_addr,
   output logic [7:0]  reg_wr_data,
   output logic        measure_en
);

   logic sclk_rise, sclk_fall, cs_fall, cs_rise, cs_n_s, mosi_s;

   spi_pin_sync u_sync (
      .sys_clk   (sys_clk),
      .reset     (reset),
      .spi_sclk  (spi_sclk),
      .spi_cs_n  (spi_cs_n),
      .spi_mosi  (spi_mosi),
      .sclk_rise (sclk_rise),
      .sclk_fall (sclk_fall),
      .cs_fall   (cs_fall),
      .cs_rise   (cs_rise),
      .cs_n_s    (cs_n_s),
      .mosi_s    (mosi_s)
   );

   state_t      state;
   logic [3:0]  bit_cnt;
   logic [6:0]  sr;
   logic [7:0]  shadow;
   logic        rw;
   logic [5:0]  addr;
   logic [7:0]  regs [64];
   logic        pend_valid;
   logic [15:0] pend_x, pend_y, pend_z;
   logic [7:0]  data_byte;
   logic        cs_idle;
`ifdef ADXL345_RESPONDER_MULTIBYTE_EN
   logic        mb;
`endif

   assign data_byte = {sr, mosi_s};
   // the CS-rise cycle still counts as selected so a coincident sample lands one cycle later
   assign cs_idle   = cs_n_s & ~cs_rise;

   function automatic logic [7:0] read_reg(input logic [5:0] a);
      if (a == REG_DEVID)
         return DEVID_VALUE;
      else if (is_writable(a) || is_sample(a))
         return regs[a];
      else
         return 8'h00;
   endfunction

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state        <= ST_WAIT_CS_HIGH;
         bit_cnt      <= 4'd0;
         sr           <= 7'd0;
         shadow       <= 8'h00;
         rw           <= 1'b0;
         addr         <= 6'd0;
         spi_miso     <= 1'b1;
         reg_wr_valid <= 1'b0;
         reg_wr_addr  <= 6'd0;
         reg_wr_data  <= 8'h00;
         pend_valid   <= 1'b0;
         pend_x       <= 16'h0000;
         pend_y       <= 16'h0000;
         pend_z       <= 16'h0000;
`ifdef ADXL345_RESPONDER_MULTIBYTE_EN
         mb           <= 1'b0;
`endif
         for (int i = 0; i < 64; i++) regs[i] <= 8'h00;
         regs[REG_BW_RATE] <= BW_RATE_RESET;
      end else begin
         reg_wr_valid <= 1'b0;

         if (sample_valid && cs_idle) begin
            {regs[REG_DATAX1], regs[REG_DATAX0]} <= sample_x;
            {regs[REG_DATAY1], regs[REG_DATAY0]} <= sample_y;
            {regs[REG_DATAZ1], regs[REG_DATAZ0]} <= sample_z;
            pend_valid <= 1'b0;
         end else if (sample_valid) begin
            pend_x     <= sample_x;
            pend_y     <= sample_y;
            pend_z     <= sample_z;
            pend_valid <= 1'b1;
         end else if (pend_valid && cs_idle) begin
            {regs[REG_DATAX1], regs[REG_DATAX0]} <= pend_x;
            {regs[REG_DATAY1], regs[REG_DATAY0]} <= pend_y;
            {regs[REG_DATAZ1], regs[REG_DATAZ0]} <= pend_z;
            pend_valid <= 1'b0;
         end

         if (cs_rise) begin
            state    <= ST_IDLE;
            spi_miso <= 1'b1;
         end else begin
            case (state)
               ST_WAIT_CS_HIGH: if (cs_n_s) state <= ST_IDLE;
               ST_IDLE: begin
                  if (cs_fall) begin
                     state   <= ST_CMD;
                     bit_cnt <= 4'd0;
                  end
               end
               ST_CMD: begin
                  if (sclk_rise) begin
                     sr      <= data_byte[6:0];
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == CMD_LAST_CNT) begin
                        rw    <= data_byte[CMD_RW_BIT];
                        addr  <= data_byte[5:0];
`ifdef ADXL345_RESPONDER_MULTIBYTE_EN
                        mb    <= data_byte[CMD_MB_BIT];
`endif
                        if (data_byte[CMD_RW_BIT]) shadow <= read_reg(data_byte[5:0]);
                        state <= ST_DATA;
                     end
                  end
               end
               ST_DATA: begin
                  if (sclk_fall && rw) begin
                     spi_miso <= shadow[7];
                     shadow   <= {shadow[6:0], 1'b0};
                  end
                  if (sclk_rise) begin
                     sr      <= data_byte[6:0];
                     bit_cnt <= bit_cnt + 4'd1;
                     if (bit_cnt == FRAME_LAST_CNT) begin
                        if (!rw) begin
                           if (is_writable(addr)) regs[addr] <= data_byte;
                           reg_wr_valid <= 1'b1;
                           reg_wr_addr  <= addr;
                           reg_wr_data  <= data_byte;
                        end
`ifdef ADXL345_RESPONDER_MULTIBYTE_EN
                        if (mb) begin
                           addr    <= addr + 6'd1;
                           bit_cnt <= DATA_FIRST_CNT;
                           if (rw) shadow <= read_reg(addr + 6'd1);
                        end else begin
                           state <= ST_DONE;
                        end
`else
                        state <= ST_DONE;
`endif
                     end
                  end
               end
               ST_DONE: ;
               default: state <= ST_WAIT_CS_HIGH;
            endcase
         end
      end
   end

   assign spi_miso_oe = ~cs_n_s & (state != ST_WAIT_CS_HIGH);
   assign measure_en  = regs[REG_POWER_CTL][3];

   // host SCLK period guard: cycles between successive synced rises
   int rise_gap;
   always_ff @(posedge sys_clk) begin
      if (reset)
         rise_gap <= 1000;
      else if (sclk_rise)
         rise_gap <= 0;
      else if (rise_gap < 1000)
         rise_gap <= rise_gap + 1;
   end

   a_sclk_ratio: assert property (@(posedge sys_clk) disable iff (reset)
      sclk_rise |-> rise_gap >= SCLK_MIN_RATIO - 1);

endmodule
